// File: rtl/muldiv_seq.sv
// Iterative 16-bit unsigned multiply/divide sequencer: one shift-add or restoring step per clock.
// Define MULDIV_DIV_EN to build the divide datapath; without it op=1 is rejected as illegal.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result_lo,
    output logic [15:0] result_hi,
    output logic [3:0]  flags,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [15:0] a_q;
    logic [31:0] acc;
    logic [31:0] step_nxt;
    logic [3:0]  fin_flags;
`ifdef MULDIV_DIV_EN
    logic [15:0] b_q;
    logic        op_q;
`endif

    // Add the multiplicand into the high half when the multiplier LSB is set, then shift the
    // 33-bit {carry, hi, lo} value right; the carry only exists between the add and the shift.
    function automatic logic [31:0] mul_step(input logic [31:0] acc_in, input logic [15:0] mcand);
        logic [16:0] sum;
        sum = {1'b0, acc_in[31:16]} + (acc_in[0] ? {1'b0, mcand} : 17'd0);
        return {sum, acc_in[15:1]};
    endfunction

`ifdef MULDIV_DIV_EN
    // Remainder lives in acc[31:16], the dividend shifts out of acc[15:0] as quotient bits shift in.
    function automatic logic [31:0] div_step(input logic [31:0] acc_in, input logic [15:0] dvs);
        logic [16:0] trial;
        logic [15:0] diff;
        trial = {acc_in[31:16], acc_in[15]};
        diff  = trial[15:0] - dvs;
        if (trial >= {1'b0, dvs})
            return {diff, acc_in[14:0], 1'b1};
        else
            return {trial[15:0], acc_in[14:0], 1'b0};
    endfunction
`endif

    always_comb begin
        step_nxt  = mul_step(acc, a_q);
        fin_flags = {1'b0, step_nxt[31], step_nxt == 32'd0, step_nxt[31:16] != 16'd0};
`ifdef MULDIV_DIV_EN
        if (op_q) begin
            step_nxt  = div_step(acc, b_q);
            fin_flags = {1'b0, step_nxt[15], step_nxt[15:0] == 16'd0, 1'b0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op) begin
`ifdef MULDIV_DIV_EN
                        state_nxt = (b == 16'd0) ? DONE : RUN;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN:     if (cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Control and visible results: cleared by reset, written only on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flags     <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (op) begin
`ifdef MULDIV_DIV_EN
                            if (b == 16'd0) begin
                                result_lo <= 16'hFFFF;
                                result_hi <= a;
                                flags     <= 4'b1100;
                                div_zero  <= 1'b1;
                            end
`else
                            result_lo <= '0;
                            result_hi <= '0;
                            flags     <= 4'b1010;
                            div_zero  <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        result_lo <= step_nxt[15:0];
                        result_hi <= step_nxt[31:16];
                        flags     <= fin_flags;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and accumulator registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q <= a;
`ifdef MULDIV_DIV_EN
            b_q  <= b;
            op_q <= op;
            acc  <= op ? {16'd0, a} : {16'd0, b};
`else
            acc  <= {16'd0, b};
`endif
        end else if (state == RUN) begin
            acc <= step_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus handshake and mid-run reset sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, op;
    logic [15:0] a, b;
    logic        busy, done, div_zero;
    logic [15:0] result_lo, result_hi;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .flags(flags), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Issue one request, then count edges until done (bounded).
    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        lat = 0; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    initial begin
        int lat, bc, ndone, d0, d1, wait_cyc;
        logic [31:0] r0, r1;
        logic prev_done;

        vecs.push_back('{1'b0, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 4'b0001, 1'b0, 16});
        vecs.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0101, 1'b0, 16});
        vecs.push_back('{1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 4'b0010, 1'b0, 16});
        vecs.push_back('{1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 1'b0, 16});
        vecs.push_back('{1'b0, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 4'b0001, 1'b0, 16});
`ifdef MULDIV_DIV_EN
        vecs.push_back('{1'b1, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 4'b0000, 1'b0, 16});
        vecs.push_back('{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b1100, 1'b1, 0});
        vecs.push_back('{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0100, 1'b0, 16});
        vecs.push_back('{1'b1, 16'h0005, 16'h0007, 16'h0000, 16'h0005, 4'b0010, 1'b0, 16});
        vecs.push_back('{1'b0, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 4'b0000, 1'b0, 16});
`else
        vecs.push_back('{1'b1, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 4'b1010, 1'b0, 0});
        vecs.push_back('{1'b0, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 4'b0000, 1'b0, 16});
`endif

        rst = 1'b1; start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        chk("reset_state", {busy, done, result_lo, result_hi, flags, div_zero}, 39'h0);
        @(posedge clk); #1;
        chk("reset_busy_hold", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat + 1);
            chk($sformatf("v%0d_result", i), {result_hi, result_lo}, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].fl});
            chk($sformatf("v%0d_div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle_after", i), {30'd0, busy, done}, 32'd0);
            chk($sformatf("v%0d_hold", i), {result_hi, result_lo}, {vecs[i].hi, vecs[i].lo});
        end

        // start held high: accepts 18 cycles apart, operands taken only at accepting edges
        ndone = 0; d0 = -1; d1 = -1; r0 = '0; r1 = '0; prev_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b1; op = 1'b0; a = 16'(k + 10); b = 16'(k + 20);
            @(posedge clk); #1;
            if (done && prev_done) chk("done_back_to_back", 32'd1, 32'd0);
            prev_done = done;
            if (done) begin
                if (ndone == 0) begin d0 = k; r0 = {result_hi, result_lo}; end
                if (ndone == 1) begin d1 = k; r1 = {result_hi, result_lo}; end
                ndone++;
            end
        end
        chk("hs_done_count", ndone, 2);
        chk("hs_first_done", d0, 16);
        chk("hs_first_result", r0, 32'd200);
        chk("hs_second_done", d1, 34);
        chk("hs_second_result", r1, 32'd1064);
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (busy && wait_cyc < 40) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("hs_drain", {31'd0, busy}, 32'd0);

        // reset at cnt==8 aborts the operation without a done pulse
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_zero", {busy, done, result_lo, result_hi, flags, div_zero}, 39'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("rst_mid_no_done", ndone, 0);
        chk("rst_mid_outputs_held", {result_hi, result_lo}, 32'h0);
        do_op(1'b0, 16'h0003, 16'h0005, lat, bc);
        chk("rst_fresh_latency", lat, 16);
        chk("rst_fresh_result", {result_hi, result_lo}, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
